// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer that drives the phase increment of the dds block.
// Define DDS_SWEEP_PINGPONG_EN to make each sweep run up to STOP and then back down to START.
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [PHASE_WIDTH-1:0] cfg_start_i,
    input  logic [PHASE_WIDTH-1:0] cfg_stop_i,
    input  logic [PHASE_WIDTH-1:0] cfg_step_i,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell_i,
    input  logic                   cfg_repeat_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    output logic [PHASE_WIDTH-1:0] phase_inc_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   wrap_o
);

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                 r_state, w_state_next;
    logic [PHASE_WIDTH-1:0] r_start, r_stop, r_step, r_phase, w_phase_next;
    logic [DWELL_WIDTH-1:0] r_dwell, r_cnt, w_cnt_next;
    logic                   r_repeat, r_done, r_wrap, w_done_next, w_wrap_next;
    logic                   w_hs, w_end;
    logic [PHASE_WIDTH-1:0] w_start_sel;
    logic [DWELL_WIDTH-1:0] w_dwell_sel, w_load_new, w_load_cur;
    logic [PHASE_WIDTH:0]   w_up;

    assign w_hs        = cfg_valid_i && (r_state == S_IDLE);
    // A config arriving together with start_i must take effect for that sweep.
    assign w_start_sel = w_hs ? cfg_start_i : r_start;
    assign w_dwell_sel = w_hs ? cfg_dwell_i : r_dwell;
    // The counter holds the number of cycles remaining after the current one.
    assign w_load_new  = (w_dwell_sel == '0) ? '0 : w_dwell_sel - 1'b1;
    assign w_load_cur  = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
    assign w_up        = {1'b0, r_phase} + {1'b0, r_step};

`ifdef DDS_SWEEP_PINGPONG_EN
    logic                 r_dir_down, w_dir_down_next;
    logic [PHASE_WIDTH:0] w_dn;
    logic                 w_dn_ok, w_pp_ok;

    assign w_dn    = {1'b0, r_phase} - {1'b0, r_step};
    assign w_dn_ok = !w_dn[PHASE_WIDTH] && (w_dn[PHASE_WIDTH-1:0] >= r_start);
    assign w_pp_ok = (r_start <= r_stop) && (r_step != '0);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) r_dir_down <= 1'b0;
        else          r_dir_down <= w_dir_down_next;
    end
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_repeat <= 1'b0;
        end else if (w_hs) begin
            r_start  <= cfg_start_i;
            r_stop   <= cfg_stop_i;
            r_step   <= cfg_step_i;
            r_dwell  <= cfg_dwell_i;
            r_repeat <= cfg_repeat_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_wrap  <= w_wrap_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_wrap_next  = 1'b0;
        w_end        = 1'b0;
`ifdef DDS_SWEEP_PINGPONG_EN
        w_dir_down_next = r_dir_down;
`endif
        if (abort_i) begin
            w_state_next = S_IDLE;
            w_phase_next = '0;
            w_cnt_next   = '0;
`ifdef DDS_SWEEP_PINGPONG_EN
            w_dir_down_next = 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_next = S_SWEEP;
                        w_phase_next = w_start_sel;
                        w_cnt_next   = w_load_new;
`ifdef DDS_SWEEP_PINGPONG_EN
                        w_dir_down_next = 1'b0;
`endif
                    end
                end
                S_SWEEP: begin
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - 1'b1;
                    end else begin
                        w_cnt_next = w_load_cur;
`ifdef DDS_SWEEP_PINGPONG_EN
                        if (r_dir_down) begin
                            if (w_dn_ok) w_phase_next = w_dn[PHASE_WIDTH-1:0];
                            else         w_end = 1'b1;
                        end else if (w_up <= {1'b0, r_stop}) begin
                            w_phase_next = w_up[PHASE_WIDTH-1:0];
                        end else if (w_pp_ok && w_dn_ok) begin
                            w_dir_down_next = 1'b1;
                            w_phase_next    = w_dn[PHASE_WIDTH-1:0];
                        end else begin
                            w_end = 1'b1;
                        end
`else
                        if (w_up <= {1'b0, r_stop}) w_phase_next = w_up[PHASE_WIDTH-1:0];
                        else                        w_end = 1'b1;
`endif
                        if (w_end) begin
`ifdef DDS_SWEEP_PINGPONG_EN
                            w_dir_down_next = 1'b0;
`endif
                            if (r_repeat) begin
                                w_phase_next = r_start;
                                w_wrap_next  = 1'b1;
                            end else begin
                                w_state_next = S_IDLE;
                                w_phase_next = '0;
                                w_cnt_next   = '0;
                                w_done_next  = 1'b1;
                            end
                        end
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign phase_inc_o = r_phase;
    assign busy_o      = (r_state == S_SWEEP);
    assign cfg_ready_o = (r_state == S_IDLE);
    assign done_o      = r_done;
    assign wrap_o      = r_wrap;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomised and directed bench for dds_sweep_ctrl, checked against a list-based sweep model.
// Also exercises the ping-pong sweep when DDS_SWEEP_PINGPONG_EN is defined.
module tb_dds_sweep_ctrl;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [15:0] cfg_start_i = '0, cfg_stop_i = '0, cfg_step_i = '0;
    logic [15:0] cfg_dwell_i = '0;
    logic        cfg_repeat_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] phase_inc_o;
    logic        busy_o, done_o, wrap_o;

    int nChecks = 0;
    int nPass   = 0;
    logic [19:0] expQ[$];

    dds_sweep_ctrl #(.PHASE_WIDTH(16), .DWELL_WIDTH(16)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i),
        .cfg_step_i(cfg_step_i), .cfg_dwell_i(cfg_dwell_i),
        .cfg_repeat_i(cfg_repeat_i), .start_i(start_i), .abort_i(abort_i),
        .phase_inc_o(phase_inc_o), .busy_o(busy_o), .done_o(done_o), .wrap_o(wrap_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [19:0] pack(int ph, logic r, logic b, logic d, logic w);
        logic [15:0] p;
        p = ph[15:0];
        return {p, r, b, d, w};
    endfunction

    // Expected per-cycle {phase, ready, busy, done, wrap} from the sweep value list.
    task automatic build_expected(input int st, input int sp, input int sg, input int dw,
                                  input int rep, input int n);
        int vals[$];
        int v, d, pass;
        expQ.delete();
        d = (dw == 0) ? 1 : dw;
        if (sg == 0 && st <= sp) begin
            repeat (n) expQ.push_back(pack(st, 0, 1, 0, 0));
            return;
        end
        v = st;
        vals.push_back(v);
        while (v + sg <= sp) begin
            v = v + sg;
            vals.push_back(v);
        end
`ifdef DDS_SWEEP_PINGPONG_EN
        if (st <= sp && sg != 0) begin
            v = v - sg;
            while (v >= st) begin
                vals.push_back(v);
                v = v - sg;
            end
        end
`endif
        pass = 0;
        while (expQ.size() < n) begin
            foreach (vals[i])
                for (int k = 0; k < d; k++)
                    expQ.push_back(pack(vals[i], 0, 1, 0, (pass > 0 && i == 0 && k == 0)));
            if (rep == 0) begin
                expQ.push_back(pack(0, 1, 0, 1, 0));
                while (expQ.size() < n) expQ.push_back(pack(0, 1, 0, 0, 0));
            end
            pass++;
        end
        while (expQ.size() > n) void'(expQ.pop_back());
    endtask

    task automatic applyStimulus(input int st, input int sp, input int sg, input int dw,
                                 input int rep, input bit withCfg);
        @(negedge clk_i);
        cfg_start_i  = st[15:0];
        cfg_stop_i   = sp[15:0];
        cfg_step_i   = sg[15:0];
        cfg_dwell_i  = dw[15:0];
        cfg_repeat_i = rep[0];
        cfg_valid_i  = withCfg;
        start_i      = 1'b1;
        @(negedge clk_i);
        cfg_valid_i  = 1'b0;
        start_i      = 1'b0;
    endtask

    task automatic do_abort();
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
    endtask

    task automatic test_reset();
        nChecks++;
        if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== pack(0, 1, 0, 0, 0))
            $display("[TB] FAIL reset_state: got %h expected %h",
                     {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, pack(0, 1, 0, 0, 0));
        else nPass++;
    endtask

    task automatic test_sweep(input string name, input int st, input int sp, input int sg,
                              input int dw, input int rep, input int n);
        applyStimulus(st, sp, sg, dw, rep, 1'b1);
        build_expected(st, sp, sg, dw, rep, n);
        for (int i = 0; i < n; i++) begin
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== expQ[i])
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, expQ[i]);
            else nPass++;
            @(negedge clk_i);
        end
        do_abort();
    endtask

    task automatic test_repeat_abort();
        applyStimulus(5, 7, 1, 1, 1, 1'b1);
        build_expected(5, 7, 1, 1, 1, 11);
        for (int i = 0; i < 11; i++) begin
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== expQ[i])
                $display("[TB] FAIL repeat cycle %0d: got %h expected %h", i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, expQ[i]);
            else nPass++;
            @(negedge clk_i);
        end
        do_abort();
        for (int i = 0; i < 3; i++) begin
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== pack(0, 1, 0, 0, 0))
                $display("[TB] FAIL abort cycle %0d: got %h expected %h", i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, pack(0, 1, 0, 0, 0));
            else nPass++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_handshake();
        applyStimulus(20, 60, 10, 2, 1, 1'b1);
        build_expected(20, 60, 10, 2, 1, 14);
        for (int i = 0; i < 14; i++) begin
            cfg_valid_i = 1'b1;
            cfg_start_i = 16'($urandom_range(1000, 2000));
            cfg_stop_i  = 16'($urandom_range(3000, 4000));
            cfg_step_i  = 16'($urandom_range(1, 9));
            cfg_dwell_i = 16'($urandom_range(0, 5));
            cfg_repeat_i = 1'b0;
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== expQ[i])
                $display("[TB] FAIL cfg_in_sweep cycle %0d: got %h expected %h", i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, expQ[i]);
            else nPass++;
            @(negedge clk_i);
        end
        cfg_valid_i = 1'b0;
        do_abort();
        applyStimulus(0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== expQ[i])
                $display("[TB] FAIL cfg_kept cycle %0d: got %h expected %h", i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, expQ[i]);
            else nPass++;
            @(negedge clk_i);
        end
        do_abort();
    endtask

    task automatic test_reset_mid();
        applyStimulus(1000, 2000, 7, 2, 1, 1'b1);
        repeat (5) @(negedge clk_i);
        #2 arstn_i = 1'b0;
        #1;
        nChecks++;
        if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== pack(0, 1, 0, 0, 0))
            $display("[TB] FAIL async_reset: got %h expected %h",
                     {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, pack(0, 1, 0, 0, 0));
        else nPass++;
        @(negedge clk_i);
        arstn_i = 1'b1;
        // Config was cleared, so a bare start holds phase 0 with STEP 0.
        applyStimulus(0, 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            nChecks++;
            if ({phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o} !== pack(0, 0, 1, 0, 0))
                $display("[TB] FAIL cfg_lost cycle %0d: got %h expected %h", i,
                         {phase_inc_o, cfg_ready_o, busy_o, done_o, wrap_o}, pack(0, 0, 1, 0, 0));
            else nPass++;
            @(negedge clk_i);
        end
        do_abort();
    endtask

    task automatic test_random();
        int st, sp, sg, dw, rep;
        for (int t = 0; t < 20; t++) begin
            st  = $urandom_range(0, 65535);
            sp  = (($urandom_range(0, 7) == 0) ? st - $urandom_range(1, 50)
                                               : st + $urandom_range(0, 80));
            if (sp > 65535) sp = 65535;
            if (sp < 0) sp = 0;
            sg  = $urandom_range(1, 30);
            dw  = $urandom_range(0, 3);
            rep = $urandom_range(0, 1);
            test_sweep("random", st, sp, sg, dw, rep, 40);
        end
    endtask

    initial begin
        #12;
        test_reset();
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_sweep("basic", 100, 130, 10, 3, 0, 16);
        test_sweep("nonexact", 0, 25, 10, 0, 0, 6);
        test_sweep("overflow", 16'hFFF0, 16'hFFFF, 8, 1, 0, 5);
        test_sweep("start_gt_stop", 50, 40, 5, 2, 0, 5);
        test_sweep("step_zero", 300, 400, 0, 1, 0, 1000);
        test_repeat_abort();
        test_handshake();
        test_reset_mid();
`ifdef DDS_SWEEP_PINGPONG_EN
        test_sweep("pingpong", 0, 20, 10, 1, 0, 8);
        test_sweep("pingpong_rep", 0, 20, 10, 2, 1, 24);
`endif
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
